// File: rtl/instr_fetch_if.sv
// L1 instruction-cache read port.
//   L1_read  : read request (fetch -> L1)
//   L1_addr  : word-aligned fetch address (fetch -> L1)
//   L1_busy  : access not complete this cycle (L1 -> fetch)
//   L1_rdata : instruction word, valid when L1_busy is low (L1 -> fetch)
interface instr_fetch_if #(
    parameter int n = 32
);
    logic         L1_read;
    logic [n-1:0] L1_addr;
    logic         L1_busy;
    logic [n-1:0] L1_rdata;

    modport master (
        output L1_read,
        output L1_addr,
        input  L1_busy,
        input  L1_rdata
    );

    modport slave (
        input  L1_read,
        input  L1_addr,
        output L1_busy,
        output L1_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. It owns the program counter, reads words from the
// L1 instruction cache and feeds the IF/ID instruction register. It handles
// branch redirects, including redirects that arrive while an L1 access is
// stalled, and counts stall cycles.
//   clk                : rising-edge clock
//   reset_n            : asynchronous active-low reset
//   l1                 : L1 read port (master side)
//   branch_instruction : redirect request
//   branch_target      : redirect address
//   instruction_next   : instruction word to the instruction register
//   pc_next            : address of instruction_next
//   pc_plus_four_next  : pc_next + 4
//   stall_count        : saturating count of stalled cycles
//
// state         | meaning
// BOOT          | one idle cycle after reset, no L1 request
// FETCH         | normal fetch at pc
// REDIRECT_WAIT | redirect taken mid-stall; old access finishes, data dropped
module instr_fetch #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [n-1:0] NOP      = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset_n,
    instr_fetch_if.master       l1,
    input  logic                branch_instruction,
    input  logic [n-1:0]        branch_target,
    output logic [n-1:0]        instruction_next,
    output logic [n-1:0]        pc_next,
    output logic [n-1:0]        pc_plus_four_next,
    output logic [15:0]         stall_count
);

    typedef enum logic [1:0] {
        BOOT          = 2'd0,
        FETCH         = 2'd1,
        REDIRECT_WAIT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] pending_q, pending_d;
    logic [15:0]  stall_q, stall_d;
    logic [n-1:0] target_aligned;

    assign target_aligned = {branch_target[n-1:2], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        stall_d   = stall_q;

        // Outputs depend only on registered state, pc and the L1 response;
        // the branch inputs only steer next-state.
        l1.L1_read        = 1'b0;
        l1.L1_addr        = pc_q;
        instruction_next  = NOP;

        if (state_q != BOOT && l1.L1_busy && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                l1.L1_read = 1'b1;
                if (!l1.L1_busy) begin
                    instruction_next = l1.L1_rdata;
                    pc_d = branch_instruction ? target_aligned : pc_q + n'(4);
                end else if (branch_instruction) begin
                    pending_d = target_aligned;
                    state_d   = REDIRECT_WAIT;
                end
            end
            REDIRECT_WAIT: begin
                // L1_addr stays at the old pc until the outstanding access
                // completes; its data is wrong-path and is replaced by NOP.
                l1.L1_read = 1'b1;
                if (!l1.L1_busy) begin
                    pc_d    = branch_instruction ? target_aligned : pending_q;
                    state_d = FETCH;
                end else if (branch_instruction) begin
                    pending_d = target_aligned;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc_next           = pc_q;
    assign pc_plus_four_next = pc_q + n'(4);
    assign stall_count       = stall_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. A second instance built with
// RESET_PC = 0xFFFF_FFFC checks address wrap-around.
module tb_instr_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        branch_instruction;
    logic [31:0] branch_target;
    logic [31:0] instruction_next, pc_next, pc_plus_four_next;
    logic [15:0] stall_count;
    logic [31:0] instruction_next2, pc_next2, pc_plus_four_next2;
    logic [15:0] stall_count2;

    int n_checks;
    int n_errors;

    instr_fetch_if #(.n(32)) bus  ();
    instr_fetch_if #(.n(32)) bus2 ();

    instr_fetch #(.n(32), .RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .l1                 (bus.master),
        .branch_instruction (branch_instruction),
        .branch_target      (branch_target),
        .instruction_next   (instruction_next),
        .pc_next            (pc_next),
        .pc_plus_four_next  (pc_plus_four_next),
        .stall_count        (stall_count)
    );

    instr_fetch #(.n(32), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP_W)) dut_wrap (
        .clk                (clk),
        .reset_n            (reset_n),
        .l1                 (bus2.master),
        .branch_instruction (1'b0),
        .branch_target      (32'h0),
        .instruction_next   (instruction_next2),
        .pc_next            (pc_next2),
        .pc_plus_four_next  (pc_plus_four_next2),
        .stall_count        (stall_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a rising edge; the caller checks at the next
    // falling edge and then advances with next_edge.
    task automatic drive(input logic busy, input logic [31:0] rdata,
                         input logic br, input logic [31:0] tgt);
        bus.L1_busy        = busy;
        bus.L1_rdata       = rdata;
        branch_instruction = br;
        branch_target      = tgt;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] rdata,
                             input logic [31:0] exp_pc);
        drive(1'b0, rdata, 1'b0, 32'h0);
        chk({tag, "_addr"}, bus.L1_addr, exp_pc);
        chk({tag, "_instr"}, instruction_next, rdata);
        chk({tag, "_pc"}, pc_next, exp_pc);
        next_edge();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus.L1_busy  = 1'b0;
        bus.L1_rdata = 32'h0;
        bus2.L1_busy  = 1'b0;
        bus2.L1_rdata = 32'hAAAA_0001;
        branch_instruction = 1'b0;
        branch_target      = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", {31'b0, bus.L1_read}, 32'h0);
        chk("rst_addr", bus.L1_addr, 32'h0);
        chk("rst_stall", {16'b0, stall_count}, 32'h0);

        // Release, BOOT cycle, then a short stall on dut and wrap on dut_wrap.
        reset_n = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        chk("boot_read", {31'b0, bus.L1_read}, 32'h0);
        chk("boot_instr", instruction_next, NOP_W);
        chk("boot_read2", {31'b0, bus2.L1_read}, 32'h0);
        next_edge();
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        chk("stall1_read", {31'b0, bus.L1_read}, 32'h1);
        chk("stall1_instr", instruction_next, NOP_W);
        chk("wrap_addr0", bus2.L1_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus_four_next2, 32'h0);
        next_edge();
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        chk("wrap_addr1", bus2.L1_addr, 32'h0);
        next_edge();
        chk("stall_two", {16'b0, stall_count}, 32'h2);

        // Asynchronous reset in the middle of the stall.
        reset_n = 1'b0;
        #1;
        chk("arst_stall", {16'b0, stall_count}, 32'h0);
        chk("arst_read", {31'b0, bus.L1_read}, 32'h0);
        next_edge();
        reset_n = 1'b1;
        drive(1'b0, 32'h1111_1111, 1'b0, 32'h0);
        chk("boot2_read", {31'b0, bus.L1_read}, 32'h0);
        chk("boot2_addr", bus.L1_addr, 32'h0);
        next_edge();

        fetch_chk("f0", 32'hA000_000A, 32'h0);
        fetch_chk("f1", 32'hB000_000B, 32'h4);
        fetch_chk("f2", 32'hC000_000C, 32'h8);
        fetch_chk("f3", 32'hD000_000D, 32'hC);

        // Unstalled branch to an unaligned target.
        drive(1'b0, 32'hE000_000E, 1'b1, 32'h0000_0103);
        chk("ubr_instr", instruction_next, 32'hE000_000E);
        chk("ubr_pc", pc_next, 32'h10);
        next_edge();
        drive(1'b0, 32'h1234_5678, 1'b1, 32'h0000_0020);
        chk("ubr_addr", bus.L1_addr, 32'h100);
        chk("ubr_pc4", pc_plus_four_next, 32'h104);
        next_edge();

        // Branch during a 3-cycle stall at 0x20.
        drive(1'b1, 32'hBAD0_0001, 1'b1, 32'h0000_0080);
        chk("sbr_addr0", bus.L1_addr, 32'h20);
        chk("sbr_instr0", instruction_next, NOP_W);
        next_edge();
        drive(1'b1, 32'hBAD0_0002, 1'b0, 32'h0);
        chk("sbr_addr1", bus.L1_addr, 32'h20);
        next_edge();
        drive(1'b1, 32'hBAD0_0003, 1'b0, 32'h0);
        chk("sbr_addr2", bus.L1_addr, 32'h20);
        next_edge();
        drive(1'b0, 32'hBAD0_0004, 1'b0, 32'h0);
        chk("sbr_drop", instruction_next, NOP_W);
        chk("sbr_addr3", bus.L1_addr, 32'h20);
        next_edge();
        drive(1'b1, 32'h0, 1'b1, 32'h0000_0080);
        chk("sbr_target", bus.L1_addr, 32'h80);
        chk("sbr_stalls", {16'b0, stall_count}, 32'h3);
        next_edge();

        // Second redirect during the same stall wins.
        drive(1'b1, 32'h0, 1'b1, 32'h0000_0200);
        chk("two_addr", bus.L1_addr, 32'h80);
        next_edge();
        drive(1'b0, 32'hBAD0_0005, 1'b0, 32'h0);
        chk("two_drop", instruction_next, NOP_W);
        next_edge();
        drive(1'b1, 32'h0, 1'b1, 32'h0000_0300);
        chk("two_target", bus.L1_addr, 32'h200);
        next_edge();

        // A branch presented on the cycle the stall ends overrides pending.
        drive(1'b0, 32'hBAD0_0006, 1'b1, 32'h0000_0405);
        chk("late_drop", instruction_next, NOP_W);
        next_edge();
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        chk("late_target", bus.L1_addr, 32'h404);
        chk("late_stalls", {16'b0, stall_count}, 32'h6);

        // Saturation: stay stalled far beyond 2^16 cycles.
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", {16'b0, stall_count}, 32'h0000_FFFF);
        chk("sat_addr", bus.L1_addr, 32'h404);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
